// File: rtl/sio_host.sv
// sio_host: host end of the 2-bit DDR half-duplex remote IO link.
// Each frame sends a start symbol and a 20-bit {addr, wdata} command, releases
// the line, then captures the returned byte stream: ADC samples followed by
// one register readback byte.
module sio_host #(
    parameter int FRAME    = 128,
    parameter int RX_FIRST = 16,
    parameter int NBYTES   = 26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic [1:0]  sdio_out,
    output logic        sdio_oe,
    input  logic [1:0]  sdio_in,
    output logic [7:0]  sample_data,
    output logic        sample_valid,
    output logic [4:0]  sample_index,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [3:0]  rd_addr,
    output logic        frame_start
);
    // state   | meaning
    // ST_IDLE | line released, t held at 0, waiting for enable at a frame boundary
    // ST_RUN  | frame in progress, t advances every clock up to FRAME-1
    localparam int TW = $clog2(FRAME);
    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_RUN  = 1'b1;
    localparam logic [TW-1:0] T_LAST  = TW'(FRAME - 1);
    localparam logic [TW-1:0] T_TURN  = TW'(10);
    localparam logic [TW-1:0] T_RX0   = TW'(RX_FIRST);
    localparam logic [TW:0]   RX_LEN  = (TW+1)'(4 * NBYTES);
    localparam logic [4:0]    K_LAST  = 5'(NBYTES - 1);

    logic [0:0]    state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic          hold_full_q;
    logic [19:0]   hold_cmd_q;
    logic [19:0]   cmd_sr_q, cmd_sr_d;
    logic [3:0]    frame_addr_q;
    logic [1:0]    sdio_out_q, sdio_out_d;
    logic          sdio_oe_q, sdio_oe_d;
    logic          frame_start_q;
    logic [5:0]    rx_sr_q;
    logic [7:0]    sample_data_q, rd_data_q;
    logic [4:0]    sample_index_q;
    logic          sample_valid_q, rd_valid_q;
    logic [3:0]    rd_addr_q;

    logic          running, frame_end, start, load, accept;
    logic [19:0]   load_cmd;
    logic [TW-1:0] rel;
    logic          in_win, byte_done, last_byte;
    logic [4:0]    byte_k;
    logic [7:0]    rx_byte;

    assign running   = (state_q == ST_RUN);
    assign frame_end = running && (t_q == T_LAST);
    assign load      = running && (t_q == '0);
    assign load_cmd  = hold_full_q ? hold_cmd_q : 20'd0;
    assign accept    = cmd_valid && !hold_full_q;

    assign rel       = t_q - T_RX0;
    assign in_win    = running && (t_q >= T_RX0) && ({1'b0, rel} < RX_LEN);
    assign byte_done = in_win && (rel[1:0] == 2'b11);
    assign byte_k    = 5'(rel >> 2);
    assign last_byte = (byte_k == K_LAST);
    assign rx_byte   = {rx_sr_q, sdio_in};

    // Frame sequencing: enable is only looked at on a frame boundary.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        start   = 1'b0;
        if (enable && (!running || frame_end)) begin
            start   = 1'b1;
            state_d = ST_RUN;
            t_d     = '0;
        end else if (frame_end) begin
            state_d = ST_IDLE;
            t_d     = '0;
        end else if (running) begin
            t_d = t_q + 1'b1;
        end
    end

    // Transmit symbol for the cycle about to begin; the command is taken from
    // the holding register on the edge leaving t=0, so it drives t=1 directly.
    always_comb begin
        sdio_out_d = 2'b11;
        sdio_oe_d  = 1'b0;
        cmd_sr_d   = cmd_sr_q;
        if (start) begin
            sdio_out_d = 2'b00;
            sdio_oe_d  = 1'b1;
        end else if (running && t_q < T_TURN) begin
            sdio_oe_d = 1'b1;
            if (load) begin
                sdio_out_d = load_cmd[19:18];
                cmd_sr_d   = {load_cmd[17:0], 2'b00};
            end else begin
                sdio_out_d = cmd_sr_q[19:18];
                cmd_sr_d   = {cmd_sr_q[17:0], 2'b00};
            end
        end else if (running && t_q == T_TURN) begin
            sdio_oe_d = 1'b1;
        end
    end

    // Frame counter, transmit registers and the single-entry command holding register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            t_q           <= '0;
            cmd_sr_q      <= '0;
            sdio_out_q    <= 2'b11;
            sdio_oe_q     <= 1'b0;
            frame_start_q <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_cmd_q    <= '0;
            frame_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            t_q           <= t_d;
            cmd_sr_q      <= cmd_sr_d;
            sdio_out_q    <= sdio_out_d;
            sdio_oe_q     <= sdio_oe_d;
            frame_start_q <= start;
            if (load) frame_addr_q <= load_cmd[19:16];
            if (accept) begin
                hold_full_q <= 1'b1;
                hold_cmd_q  <= {cmd_addr, cmd_wdata};
            end else if (load) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    // Receive shifter and byte strobes; a strobe follows the byte's last capture by one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_sr_q        <= '0;
            sample_data_q  <= '0;
            sample_index_q <= '0;
            sample_valid_q <= 1'b0;
            rd_data_q      <= '0;
            rd_addr_q      <= '0;
            rd_valid_q     <= 1'b0;
        end else begin
            sample_valid_q <= byte_done && !last_byte;
            rd_valid_q     <= byte_done && last_byte;
            if (in_win) rx_sr_q <= rx_byte[5:0];
            if (byte_done && !last_byte) begin
                sample_data_q  <= rx_byte;
                sample_index_q <= byte_k;
            end
            if (byte_done && last_byte) begin
                rd_data_q <= rx_byte;
                rd_addr_q <= frame_addr_q;
            end
        end
    end

    assign cmd_ready    = !hold_full_q;
    assign sdio_out     = sdio_out_q;
    assign sdio_oe      = sdio_oe_q;
    assign frame_start  = frame_start_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign sample_index = sample_index_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign rd_addr      = rd_addr_q;
endmodule
